dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (CPU side) and a DMA/debug-loader port.
- Sits between the mem stage and the data memory.
- The CPU has priority. A wait counter bounds DMA starvation by forcing one DMA slot and stalling the CPU for that cycle.
- Return data from the memory's 1-cycle synchronous read is routed back to the requester that issued the read.

Parameters:
ADDR_WIDTH, 12, data-memory address width
WORD_WIDTH, 16, data-memory word width
MAX_WAIT, 8, consecutive denied DMA cycles before a forced DMA slot (legal range 1..2**CNT_WIDTH-1)
CNT_WIDTH, 4, wait-counter width

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
in_cpu_rd_en  in  1  CPU read request this cycle
in_cpu_rd_addr  in  ADDR_WIDTH  CPU read address
in_cpu_wr_en  in  1  CPU write request this cycle
in_cpu_wr_addr  in  ADDR_WIDTH  CPU write address
in_cpu_wr_word  in  WORD_WIDTH  CPU write data
out_cpu_stall  out  1  CPU request denied this cycle; CPU holds its request
out_cpu_rd_word  out  WORD_WIDTH  read data to CPU (valid the cycle after a granted CPU read)
in_dma_req  in  1  DMA access request; held with payload until granted
in_dma_we  in  1  1 = write, 0 = read
in_dma_addr  in  ADDR_WIDTH  DMA address
in_dma_wr_word  in  WORD_WIDTH  DMA write data
out_dma_gnt  out  1  DMA access accepted this cycle
out_dma_rd_valid  out  1  DMA read data valid on out_dma_rd_word
out_dma_rd_word  out  WORD_WIDTH  DMA read data
out_mem_rd_addr  out  ADDR_WIDTH  to memory read address
out_mem_wr_addr  out  ADDR_WIDTH  to memory write address
out_mem_wr_word  out  WORD_WIDTH  to memory write data
out_mem_write_en  out  1  to memory write enable
in_mem_rd_word  in  WORD_WIDTH  memory read data, 1 cycle after address

Behaviour:
- State registers:
  - wait_cnt[CNT_WIDTH]
  - force_dma (1 bit)
  - rd_owner (0 = CPU, 1 = DMA)
  - dma_rd_valid_q
- Reset (reset low, asynchronous): wait_cnt = 0, force_dma = 0, rd_owner = 0, dma_rd_valid_q = 0.
  - Combinational outputs at reset with idle inputs: stall = 0, gnt = 0, rd_valid = 0, write_en = 0, mem addresses = CPU addresses.
- cpu_act = in_cpu_rd_en | in_cpu_wr_en. Exactly one requester owns the port per cycle.
- Grant logic (combinational):
  - force_dma = 1 and in_dma_req: DMA wins; out_cpu_stall = cpu_act.
  - Else if cpu_act: CPU wins; out_dma_gnt = 0.
  - Else if in_dma_req: DMA wins; no stall.
  - Else: idle.
- Memory drive:
  - CPU owner: rd_addr = cpu_rd_addr; wr_addr/word = CPU values; write_en = in_cpu_wr_en. CPU read and write may occur in the same cycle.
  - DMA owner: rd_addr = wr_addr = in_dma_addr; wr_word = in_dma_wr_word; write_en = in_dma_we.
  - Idle or stalled CPU: write_en = 0; rd_addr = cpu_rd_addr.
- Wait counter:
  - DMA requested and denied: wait_cnt += 1, saturating at 2**CNT_WIDTH-1.
  - DMA granted, or no request: wait_cnt = 0.
  - force_dma is set on the edge where a denied cycle leaves wait_cnt == MAX_WAIT-1, i.e. after MAX_WAIT consecutive denials.
  - force_dma clears on any DMA grant.
  - Result: a requesting DMA is granted no later than cycle MAX_WAIT+1 after its request.
- Read return:
  - On a granted DMA read: dma_rd_valid_q <= 1 and rd_owner <= 1; otherwise dma_rd_valid_q <= 0.
  - On a granted CPU read: rd_owner <= 0.
  - out_dma_rd_word = in_mem_rd_word; out_dma_rd_valid = dma_rd_valid_q.
  - out_cpu_rd_word = in_mem_rd_word; meaningful only when rd_owner = 0.
- Back-to-back DMA grants are allowed every cycle while the CPU is idle; rd_valid then stays high continuously.
- Simultaneous CPU write and forced DMA write to the same address: only the DMA write occurs that cycle; the CPU write completes the next cycle (the CPU write wins last).
- in_dma_req dropped before grant: wait_cnt clears. force_dma persists until the next DMA grant.
- Reset asserted mid-transfer: a pending DMA read's valid is lost; the requester reissues.
- Latency: grant is 0 cycles; read data is 1 cycle.

Test Plan:
- CPU idle, DMA read addr 0x010 (mem holds 0x1234) -> gnt same cycle; next cycle rd_valid = 1, rd_word = 0x1234; stall never 1.
- CPU read every cycle, DMA write 0xBEEF to 0x020, MAX_WAIT = 8 -> gnt low for 8 cycles, gnt high and stall high in cycle 9; mem[0x020] = 0xBEEF; wait_cnt = 0 afterwards.
- CPU writes 0x0001 to 0x005 while a forced DMA writes 0x0002 to 0x005 -> DMA write first, CPU write in the next cycle; final mem[0x005] = 0x0001.
- CPU idle, DMA reads 0x000..0x003 back-to-back -> four consecutive gnts; rd_valid high for 4 cycles with the matching words in order.
- DMA read granted, then reset pulled low before the next edge -> rd_valid = 0, wait_cnt = 0, force_dma = 0 immediately; write_en = 0.
- DMA req held 3 cycles against CPU traffic, then dropped -> wait_cnt returns to 0; no forced slot and no stall follows.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and a DMA/debug-loader port. The CPU normally wins. A wait counter bounds
// DMA starvation by forcing one DMA slot, stalling the CPU for that cycle.
// Read data from the 1-cycle synchronous memory is steered back to whichever
// requester issued the read.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 16,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_cpu_rd_en,
  input  logic [ADDR_WIDTH-1:0] in_cpu_rd_addr,
  input  logic                  in_cpu_wr_en,
  input  logic [ADDR_WIDTH-1:0] in_cpu_wr_addr,
  input  logic [WORD_WIDTH-1:0] in_cpu_wr_word,
  output logic                  out_cpu_stall,
  output logic [WORD_WIDTH-1:0] out_cpu_rd_word,
  input  logic                  in_dma_req,
  input  logic                  in_dma_we,
  input  logic [ADDR_WIDTH-1:0] in_dma_addr,
  input  logic [WORD_WIDTH-1:0] in_dma_wr_word,
  output logic                  out_dma_gnt,
  output logic                  out_dma_rd_valid,
  output logic [WORD_WIDTH-1:0] out_dma_rd_word,
  output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [WORD_WIDTH-1:0] out_mem_wr_word,
  output logic                  out_mem_write_en,
  input  logic [WORD_WIDTH-1:0] in_mem_rd_word
);

  localparam logic [CNT_WIDTH-1:0] CntSat   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CntForce = CNT_WIDTH'(MAX_WAIT - 1);

  logic                 cpuAct;
  logic                 dmaWin;
  logic                 cpuWin;
  logic [CNT_WIDTH-1:0] waitCnt_q, waitCnt_d;
  logic                 forceDma_q, forceDma_d;
  logic                 rdOwner_q, rdOwner_d;
  logic                 dmaRdValid_q, dmaRdValid_d;

  // Decide who owns the memory port this cycle; a pending forced slot beats the CPU.
  always_comb begin
    cpuAct        = in_cpu_rd_en | in_cpu_wr_en;
    dmaWin        = in_dma_req & (forceDma_q | ~cpuAct);
    cpuWin        = cpuAct & ~dmaWin;
    out_dma_gnt   = dmaWin;
    out_cpu_stall = cpuAct & dmaWin;
  end

  // Steer the memory port from the owner; idle and stalled cycles never write.
  always_comb begin
    out_mem_rd_addr  = in_cpu_rd_addr;
    out_mem_wr_addr  = in_cpu_wr_addr;
    out_mem_wr_word  = in_cpu_wr_word;
    out_mem_write_en = 1'b0;
    if (dmaWin) begin
      out_mem_rd_addr  = in_dma_addr;
      out_mem_wr_addr  = in_dma_addr;
      out_mem_wr_word  = in_dma_wr_word;
      out_mem_write_en = in_dma_we;
    end else if (cpuWin) begin
      out_mem_write_en = in_cpu_wr_en;
    end
  end

  // Next-state for starvation tracking and read-return routing.
  always_comb begin
    waitCnt_d    = '0;
    forceDma_d   = forceDma_q;
    rdOwner_d    = rdOwner_q;
    dmaRdValid_d = dmaWin & ~in_dma_we;
    if (in_dma_req && !dmaWin) begin
      waitCnt_d = (waitCnt_q == CntSat) ? waitCnt_q : waitCnt_q + 1'b1;
    end
    if (dmaWin) begin
      forceDma_d = 1'b0;
    end else if (in_dma_req && waitCnt_q == CntForce) begin
      forceDma_d = 1'b1;
    end
    if (dmaWin && !in_dma_we) begin
      rdOwner_d = 1'b1;
    end else if (cpuWin && in_cpu_rd_en) begin
      rdOwner_d = 1'b0;
    end
  end

  // State registers; async active-low reset drops any in-flight DMA read valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt_q    <= '0;
      forceDma_q   <= 1'b0;
      rdOwner_q    <= 1'b0;
      dmaRdValid_q <= 1'b0;
    end else begin
      waitCnt_q    <= waitCnt_d;
      forceDma_q   <= forceDma_d;
      rdOwner_q    <= rdOwner_d;
      dmaRdValid_q <= dmaRdValid_d;
    end
  end

  // Read data returns to the requester that issued the read; the CPU copy is
  // blanked while the DMA owns the returning word.
  always_comb begin
    out_dma_rd_word  = in_mem_rd_word;
    out_dma_rd_valid = dmaRdValid_q;
    out_cpu_rd_word  = rdOwner_q ? '0 : in_mem_rd_word;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter,
// checked against a behavioural model of the arbitration rules and a
// reference copy of the data memory.
module tb_dmem_arbiter;

  localparam int AW   = 12;
  localparam int WW   = 16;
  localparam int MAXW = 8;

  logic          clock;
  logic          reset;
  logic          in_cpu_rd_en;
  logic [AW-1:0] in_cpu_rd_addr;
  logic          in_cpu_wr_en;
  logic [AW-1:0] in_cpu_wr_addr;
  logic [WW-1:0] in_cpu_wr_word;
  logic          out_cpu_stall;
  logic [WW-1:0] out_cpu_rd_word;
  logic          in_dma_req;
  logic          in_dma_we;
  logic [AW-1:0] in_dma_addr;
  logic [WW-1:0] in_dma_wr_word;
  logic          out_dma_gnt;
  logic          out_dma_rd_valid;
  logic [WW-1:0] out_dma_rd_word;
  logic [AW-1:0] out_mem_rd_addr;
  logic [AW-1:0] out_mem_wr_addr;
  logic [WW-1:0] out_mem_wr_word;
  logic          out_mem_write_en;
  logic [WW-1:0] memRdWord;

  logic [WW-1:0] dutMem [0:4095];
  logic [WW-1:0] refMem [0:4095];

  int compareCount;
  int mismatchCount;

  // Model state: consecutive denied DMA cycles and an owed DMA slot.
  int  streak;
  bit  owed;
  bit  sawGnt;
  bit  sawStall;

  dmem_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_WAIT(MAXW), .CNT_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .in_cpu_rd_en(in_cpu_rd_en), .in_cpu_rd_addr(in_cpu_rd_addr),
    .in_cpu_wr_en(in_cpu_wr_en), .in_cpu_wr_addr(in_cpu_wr_addr),
    .in_cpu_wr_word(in_cpu_wr_word),
    .out_cpu_stall(out_cpu_stall), .out_cpu_rd_word(out_cpu_rd_word),
    .in_dma_req(in_dma_req), .in_dma_we(in_dma_we), .in_dma_addr(in_dma_addr),
    .in_dma_wr_word(in_dma_wr_word),
    .out_dma_gnt(out_dma_gnt), .out_dma_rd_valid(out_dma_rd_valid),
    .out_dma_rd_word(out_dma_rd_word),
    .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
    .out_mem_wr_word(out_mem_wr_word), .out_mem_write_en(out_mem_write_en),
    .in_mem_rd_word(memRdWord)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory with a 1-cycle synchronous read (old data on same-cycle write).
  always @(posedge clock) begin
    if (out_mem_write_en) dutMem[out_mem_wr_addr] <= out_mem_wr_word;
    memRdWord <= dutMem[out_mem_rd_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // One clock of traffic: drive, check combinational outputs, advance the
  // model, cross the edge, then check the returned read data.
  task automatic applyStimulus(input bit cRd, input logic [AW-1:0] cRdA,
                               input bit cWr, input logic [AW-1:0] cWrA, input logic [WW-1:0] cWrW,
                               input bit dReq, input bit dWe, input logic [AW-1:0] dA,
                               input logic [WW-1:0] dW);
    bit cpuAct, dmaWins, cpuWins, expWe, nextDmaValid, nextCpuRd;
    logic [AW-1:0] expRdA, expWrA;
    logic [WW-1:0] expWrW, nextDmaWord, nextCpuWord;
    in_cpu_rd_en = cRd; in_cpu_rd_addr = cRdA;
    in_cpu_wr_en = cWr; in_cpu_wr_addr = cWrA; in_cpu_wr_word = cWrW;
    in_dma_req = dReq; in_dma_we = dWe; in_dma_addr = dA; in_dma_wr_word = dW;
    #2;
    cpuAct  = cRd || cWr;
    dmaWins = dReq && (owed || !cpuAct);
    cpuWins = cpuAct && !dmaWins;
    expWe   = dmaWins ? dWe : (cpuWins && cWr);
    expRdA  = dmaWins ? dA : cRdA;
    expWrA  = dmaWins ? dA : cWrA;
    expWrW  = dmaWins ? dW : cWrW;
    checkOutput("gnt", 32'(out_dma_gnt), 32'(dmaWins));
    checkOutput("stall", 32'(out_cpu_stall), 32'(cpuAct && dmaWins));
    checkOutput("writeEn", 32'(out_mem_write_en), 32'(expWe));
    checkOutput("rdAddr", 32'(out_mem_rd_addr), 32'(expRdA));
    if (expWe) begin
      checkOutput("wrAddr", 32'(out_mem_wr_addr), 32'(expWrA));
      checkOutput("wrWord", 32'(out_mem_wr_word), 32'(expWrW));
    end
    sawGnt   = out_dma_gnt;
    sawStall = out_cpu_stall;
    nextDmaValid = dmaWins && !dWe;
    nextDmaWord  = refMem[dA];
    nextCpuRd    = cpuWins && cRd;
    nextCpuWord  = refMem[cRdA];
    if (expWe) refMem[expWrA] = expWrW;
    if (dReq && !dmaWins) begin
      streak++;
      if (streak >= MAXW) owed = 1'b1;
    end else begin
      streak = 0;
    end
    if (dmaWins) owed = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("dmaValid", 32'(out_dma_rd_valid), 32'(nextDmaValid));
    if (nextDmaValid) checkOutput("dmaWord", 32'(out_dma_rd_word), 32'(nextDmaWord));
    if (nextCpuRd) checkOutput("cpuWord", 32'(out_cpu_rd_word), 32'(nextCpuWord));
  endtask

  // Asynchronous reset with idle inputs; outputs must settle without a clock edge.
  task automatic resetDut();
    in_cpu_rd_en = 1'b0; in_cpu_rd_addr = 12'h0AB;
    in_cpu_wr_en = 1'b0; in_cpu_wr_addr = 12'h0CD; in_cpu_wr_word = 16'h0;
    in_dma_req = 1'b0; in_dma_we = 1'b0; in_dma_addr = 12'h0; in_dma_wr_word = 16'h0;
    reset = 1'b0;
    #1;
    checkOutput("rstValid", 32'(out_dma_rd_valid), 32'd0);
    checkOutput("rstStall", 32'(out_cpu_stall), 32'd0);
    checkOutput("rstGnt", 32'(out_dma_gnt), 32'd0);
    checkOutput("rstWe", 32'(out_mem_write_en), 32'd0);
    checkOutput("rstRdAddr", 32'(out_mem_rd_addr), 32'h0AB);
    checkOutput("rstWrAddr", 32'(out_mem_wr_addr), 32'h0CD);
    streak = 0;
    owed   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Contend a DMA request against continuous CPU reads; report the grant cycle.
  task automatic countToGrant(input logic [AW-1:0] dA, input bit dWe, input logic [WW-1:0] dW,
                              output int cycles);
    cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 12'h030, 1'b0, 12'h000, 16'h0, 1'b1, dWe, dA, dW);
      if (sawGnt) begin
        cycles = i;
        break;
      end
    end
  endtask

  bit            rCpuRd, rCpuWr, rDmaPending, rDmaWe, rReq;
  logic [AW-1:0] rCpuRdA, rCpuWrA, rDmaA;
  logic [WW-1:0] rCpuWrW, rDmaW;
  int            cpuPct, waited, maxWaited, grantCycle;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    for (int i = 0; i < 4096; i++) begin
      dutMem[i] <= WW'(i * 37) ^ 16'h5A5A;
      refMem[i] = WW'(i * 37) ^ 16'h5A5A;
    end
    dutMem[12'h010] <= 16'h1234;
    refMem[12'h010] = 16'h1234;

    resetDut();

    // Lone DMA read with the CPU idle.
    applyStimulus(1'b0, 12'h0AB, 1'b0, 12'h0CD, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0);
    checkOutput("tp1Gnt", 32'(sawGnt), 32'd1);
    checkOutput("tp1Stall", 32'(sawStall), 32'd0);
    checkOutput("tp1Valid", 32'(out_dma_rd_valid), 32'd1);
    checkOutput("tp1Word", 32'(out_dma_rd_word), 32'h1234);

    // Back-to-back DMA reads 0x000..0x003.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 12'h0AB, 1'b0, 12'h0CD, 16'h0, 1'b1, 1'b0, AW'(i), 16'h0);
      checkOutput("tp4Gnt", 32'(sawGnt), 32'd1);
      checkOutput("tp4Valid", 32'(out_dma_rd_valid), 32'd1);
    end
    applyStimulus(1'b0, 12'h0AB, 1'b0, 12'h0CD, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);

    // Starvation bound: forced DMA write lands on cycle MAX_WAIT+1.
    countToGrant(12'h020, 1'b1, 16'hBEEF, grantCycle);
    checkOutput("tp2GntCycle", 32'(grantCycle), 32'(MAXW + 1));
    checkOutput("tp2Stall", 32'(sawStall), 32'd1);
    applyStimulus(1'b1, 12'h020, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("tp2Mem", 32'(out_cpu_rd_word), 32'hBEEF);
    countToGrant(12'h021, 1'b1, 16'h7777, grantCycle);
    checkOutput("tp2Again", 32'(grantCycle), 32'(MAXW + 1));

    // Forced DMA write and CPU write to the same address: CPU write lands last.
    repeat (MAXW) applyStimulus(1'b1, 12'h040, 1'b0, 12'h0, 16'h0, 1'b1, 1'b1, 12'h005, 16'h0002);
    applyStimulus(1'b0, 12'h040, 1'b1, 12'h005, 16'h0001, 1'b1, 1'b1, 12'h005, 16'h0002);
    checkOutput("tp3Stall", 32'(sawStall), 32'd1);
    applyStimulus(1'b0, 12'h040, 1'b1, 12'h005, 16'h0001, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("tp3CpuGo", 32'(sawStall), 32'd0);
    applyStimulus(1'b1, 12'h005, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    checkOutput("tp3Final", 32'(out_cpu_rd_word), 32'h0001);

    // DMA request dropped after 3 denials: counter restarts, no forced slot.
    repeat (3) applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h050, 16'h0);
    applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, 12'h0, 16'h0);
    countToGrant(12'h050, 1'b0, 16'h0, grantCycle);
    checkOutput("tp6GntCycle", 32'(grantCycle), 32'(MAXW + 1));

    // Reset right after a granted DMA read: valid must drop asynchronously.
    applyStimulus(1'b0, 12'h0AB, 1'b0, 12'h0CD, 16'h0, 1'b1, 1'b0, 12'h010, 16'h0);
    checkOutput("rstPreValid", 32'(out_dma_rd_valid), 32'd1);
    resetDut();

    // Reset clears a pending forced slot.
    repeat (MAXW) applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h060, 16'h0);
    resetDut();
    applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 12'h060, 16'h0);
    checkOutput("rstForceStall", 32'(sawStall), 32'd0);

    // Randomized traffic: light then heavy CPU load.
    rCpuRd = 0; rCpuWr = 0; rDmaPending = 0; maxWaited = 0; waited = 0;
    rCpuRdA = '0; rCpuWrA = '0; rCpuWrW = '0; rDmaA = '0; rDmaW = '0; rDmaWe = 0;
    sawStall = 0;
    for (int n = 0; n < 3000; n++) begin
      cpuPct = (n < 1500) ? 30 : 90;
      if (!sawStall) begin
        rCpuRd  = ($urandom_range(0, 99) < cpuPct);
        rCpuWr  = ($urandom_range(0, 99) < cpuPct / 2);
        rCpuRdA = AW'($urandom_range(0, 15));
        rCpuWrA = AW'($urandom_range(0, 15));
        rCpuWrW = WW'($urandom);
      end
      rReq = 1'b0;
      if (!rDmaPending) begin
        if ($urandom_range(0, 9) < 4) begin
          rDmaPending = 1'b1;
          rDmaWe = $urandom_range(0, 1) == 1;
          rDmaA  = AW'($urandom_range(0, 15));
          rDmaW  = WW'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        rDmaPending = 1'b0;
      end
      rReq = rDmaPending;
      applyStimulus(rCpuRd, rCpuRdA, rCpuWr, rCpuWrA, rCpuWrW, rReq, rDmaWe, rDmaA, rDmaW);
      if (rReq && !sawGnt) waited++;
      else waited = 0;
      if (waited > maxWaited) maxWaited = waited;
      if (sawGnt) rDmaPending = 1'b0;
    end
    checkOutput("starveBound", 32'(maxWaited <= MAXW), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
